arf_retire_scheduler: RTL and testbench
=======================================

// Module: arf_retire_scheduler
// PURPOSE
//  In-order retirement sequencer in front of the ARF write ports. Dispatch allocates slots in program order.
//  Execution completes slots out of order, by index, with result data. Each cycle the block retires up to
//  two of the oldest completed slots onto ARF write ports 1/2, together with write_back.
// PARAMETERS
//  AR_SIZE  6   arch register index width (arf_old_addr*)
//  PR_SIZE  6   physical register index width (arf_write_addr*)
//  DATA_W   32  result data width
//  DEPTH    16  slot count; must be a power of 2
//  IDX_W    4   slot index width; equals log2(DEPTH)
// PORTS
//  clk              in   1        clock, rising edge
//  rst              in   1        asynchronous reset, active-high
//  alloc_valid      in   1        dispatch requests a slot
//  alloc_ready      out  1        slot available (count < DEPTH); combinational
//  alloc_arch       in   AR_SIZE  architectural dest reg of allocating instr
//  alloc_phys       in   PR_SIZE  renamed (physical) dest reg of allocating instr
//  alloc_idx        out  IDX_W    slot index granted (= tail); combinational
//  cmpl_valid       in   1        execution result valid
//  cmpl_idx         in   IDX_W    slot being completed
//  cmpl_data        in   DATA_W   result value
//  flush            in   1        discard all slots (mispredict/exception)
//  arf_write_back   out  1        = arf_retire1 | arf_retire2
//  arf_retire1/2    out  1        ARF write port 1/2 enable
//  arf_write_addr1/2 out PR_SIZE  physical reg of retiring slot
//  arf_write_data1/2 out DATA_W   result of retiring slot
//  arf_old_addr1/2  out  AR_SIZE  architectural reg of retiring slot
//  count            out  IDX_W+1  occupied slots
//  empty            out  1        count == 0
// BEHAVIOUR
//  - Per-slot state: valid, done, arch, phys, data. Registers head, tail (IDX_W, wrap mod DEPTH), count.
//  - Reset (async): all slot valid/done = 0; head = tail = count = 0. All arf_* outputs = 0.
//    After reset alloc_ready = 1, empty = 1, alloc_idx = 0.
//  - Alloc: fires when alloc_valid & alloc_ready at an edge. The slot at tail is written with valid = 1, done = 0.
//    tail increments. alloc_valid while full is ignored; no state change.
//  - Complete: cmpl_valid at an edge with slot[cmpl_idx].valid sets done = 1 and stores data.
//    Completion to a non-valid slot, or to an already-done slot, is ignored.
//  - Retire select: combinational from registered state.
//    r1 = slot[head].valid & done.
//    r2 = r1 & slot[head+1].valid & done.
//    Port 2 never retires without port 1. Retirement is strictly in order.
//  - Retire outputs are registered. At the edge, arf_retire1/2 and the addr/data fields load the selected slots.
//    The retired slots' valid/done are cleared and head advances by r1+r2.
//    When nothing retires, arf_retire* = 0 and the data/addr outputs hold their last values.
//  - Latency: a completion sampled at edge T is visible at edge T+1. It appears on arf_* in the cycle after
//    edge T+1, provided it is the head or head+1 and older slots are done.
//  - A completion to head in the same cycle that head is evaluated does not retire that cycle.
//  - count_next = count + alloc_fire - r1 - r2. Alloc and retire in the same cycle are legal.
//    A full queue accepts no alloc even if it retires that cycle; alloc_ready derives from registered count.
//  - Wrap-around: head+1 and tail+1 are computed mod DEPTH. Dual retire across the DEPTH-1 -> 0 boundary is legal.
//  - Flush has priority over alloc, complete and retire in the same cycle.
//    At the next edge it clears all valid/done, sets head = tail = count = 0 and drives arf_retire1/2 = 0.
//    Nothing retires in the flush cycle.
//  - Reset asserted mid-operation: immediate return to reset state. In-flight slots are lost.
// CONFIGURATION
//  DUAL_RETIRE_EN defined: behaviour as above, up to 2 retires per cycle.
//  DUAL_RETIRE_EN undefined: r2 forced 0. arf_retire2 = 0 and arf_write_addr2/data2/old_addr2 = 0 permanently.
//  All other behaviour is unchanged.
// TESTING
//  1 Reset -> all arf_* = 0, count = 0, empty = 1, alloc_ready = 1, alloc_idx = 0.
//  2 Alloc idx0 (arch 3, phys 40) and idx1 (arch 5, phys 41). Complete idx1 = 22, then idx0 = 11.
//    -> one cycle later, retire1 = phys 40/data 11/old 3 and retire2 = phys 41/data 22/old 5 together;
//    count = 0. Without DUAL_RETIRE_EN, idx0 retires one cycle before idx1.
//  3 Fill 16 allocs -> alloc_ready = 0, count = 16. A 17th alloc_valid is ignored.
//    Complete head -> it retires and alloc_ready returns to 1.
//  4 Wrap: head = 15, tail = 1 with slots 15 and 0 done -> both retire in one cycle; head = 1, count = 0.
//  5 Alloc 3 and complete 2. Flush together with alloc_valid and cmpl_valid -> next cycle count = 0,
//    head = tail = 0, retire1/2 = 0. Later completions to the flushed indices are ignored.
//  6 Completion to a non-allocated idx 7 with data 0xDEAD -> no state change; slot 7 is not done after a later alloc.

Source files
------------

// File: rtl/arf_retire_scheduler.sv
// In-order retirement sequencer feeding the two ARF write ports.
// Optional feature macro: DUAL_RETIRE_EN (second retire port); undefined means single retire per cycle.
module arf_retire_scheduler #(
    parameter int unsigned AR_SIZE = 6,
    parameter int unsigned PR_SIZE = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic [AR_SIZE-1:0] alloc_arch,
    input  logic [PR_SIZE-1:0] alloc_phys,
    output logic [IDX_W-1:0]   alloc_idx,
    input  logic               cmpl_valid,
    input  logic [IDX_W-1:0]   cmpl_idx,
    input  logic [DATA_W-1:0]  cmpl_data,
    input  logic               flush,
    output logic               arf_write_back,
    output logic               arf_retire1,
    output logic               arf_retire2,
    output logic [PR_SIZE-1:0] arf_write_addr1,
    output logic [PR_SIZE-1:0] arf_write_addr2,
    output logic [DATA_W-1:0]  arf_write_data1,
    output logic [DATA_W-1:0]  arf_write_data2,
    output logic [AR_SIZE-1:0] arf_old_addr1,
    output logic [AR_SIZE-1:0] arf_old_addr2,
    output logic [IDX_W:0]     count,
    output logic               empty
);

    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   done_q;
    logic [AR_SIZE-1:0] arch_q [DEPTH];
    logic [PR_SIZE-1:0] phys_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];

    logic [IDX_W-1:0]   head_q, tail_q;
    logic [IDX_W:0]     count_q, count_d;

    logic               retire1_q;
    logic [PR_SIZE-1:0] waddr1_q;
    logic [DATA_W-1:0]  wdata1_q;
    logic [AR_SIZE-1:0] oaddr1_q;

    logic               alloc_fire, cmpl_fire, r1, r2;
    logic [1:0]         adv;

    assign alloc_ready = (count_q < (IDX_W+1)'(DEPTH));
    assign alloc_idx   = tail_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);

    assign alloc_fire = alloc_valid & alloc_ready & ~flush;
    assign cmpl_fire  = cmpl_valid & valid_q[cmpl_idx] & ~done_q[cmpl_idx] & ~flush;
    // flush suppresses retirement in its own cycle
    assign r1         = valid_q[head_q] & done_q[head_q] & ~flush;
    assign adv        = {1'b0, r1} + {1'b0, r2};
    assign count_d    = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(adv);

`ifdef DUAL_RETIRE_EN
    logic [IDX_W-1:0]   head_p1;
    logic               retire2_q;
    logic [PR_SIZE-1:0] waddr2_q;
    logic [DATA_W-1:0]  wdata2_q;
    logic [AR_SIZE-1:0] oaddr2_q;

    assign head_p1 = head_q + IDX_W'(1);
    assign r2      = r1 & valid_q[head_p1] & done_q[head_p1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire2_q <= 1'b0;
            waddr2_q  <= '0;
            wdata2_q  <= '0;
            oaddr2_q  <= '0;
        end else if (flush) begin
            retire2_q <= 1'b0;
        end else begin
            retire2_q <= r2;
            if (r2) begin
                waddr2_q <= phys_q[head_p1];
                wdata2_q <= data_q[head_p1];
                oaddr2_q <= arch_q[head_p1];
            end
        end
    end

    assign arf_retire2     = retire2_q;
    assign arf_write_addr2 = waddr2_q;
    assign arf_write_data2 = wdata2_q;
    assign arf_old_addr2   = oaddr2_q;
`else
    assign r2              = 1'b0;
    assign arf_retire2     = 1'b0;
    assign arf_write_addr2 = '0;
    assign arf_write_data2 = '0;
    assign arf_old_addr2   = '0;
`endif

    assign arf_retire1     = retire1_q;
    assign arf_write_addr1 = waddr1_q;
    assign arf_write_data1 = wdata1_q;
    assign arf_old_addr1   = oaddr1_q;
    assign arf_write_back  = arf_retire1 | arf_retire2;

    // Retiring slots are never the tail while not full, so retire clears and alloc writes never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            done_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            retire1_q <= 1'b0;
            waddr1_q  <= '0;
            wdata1_q  <= '0;
            oaddr1_q  <= '0;
        end else if (flush) begin
            valid_q   <= '0;
            done_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            retire1_q <= 1'b0;
        end else begin
            retire1_q <= r1;
            if (r1) begin
                waddr1_q        <= phys_q[head_q];
                wdata1_q        <= data_q[head_q];
                oaddr1_q        <= arch_q[head_q];
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
`ifdef DUAL_RETIRE_EN
            if (r2) begin
                valid_q[head_p1] <= 1'b0;
                done_q[head_p1]  <= 1'b0;
            end
`endif
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + IDX_W'(1);
            end
            if (cmpl_fire) begin
                done_q[cmpl_idx] <= 1'b1;
            end
            head_q  <= head_q + IDX_W'(adv);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            arch_q[tail_q] <= alloc_arch;
            phys_q[tail_q] <= alloc_phys;
        end
        if (cmpl_fire) begin
            data_q[cmpl_idx] <= cmpl_data;
        end
    end

endmodule

// File: tb/tb_arf_retire_scheduler.sv
// Scoreboard bench for arf_retire_scheduler; expectations adapt to DUAL_RETIRE_EN.
module tb_arf_retire_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [5:0]  alloc_arch = '0;
    logic [5:0]  alloc_phys = '0;
    logic [3:0]  alloc_idx;
    logic        cmpl_valid = 1'b0;
    logic [3:0]  cmpl_idx = '0;
    logic [31:0] cmpl_data = '0;
    logic        flush = 1'b0;
    logic        arf_write_back, arf_retire1, arf_retire2;
    logic [5:0]  arf_write_addr1, arf_write_addr2;
    logic [31:0] arf_write_data1, arf_write_data2;
    logic [5:0]  arf_old_addr1, arf_old_addr2;
    logic [4:0]  count;
    logic        empty;

    typedef struct {
        int          port;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [5:0]  old;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    arf_retire_scheduler #(.AR_SIZE(6), .PR_SIZE(6), .DATA_W(32), .DEPTH(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_arch(alloc_arch), .alloc_phys(alloc_phys), .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_data(cmpl_data),
        .flush(flush), .arf_write_back(arf_write_back),
        .arf_retire1(arf_retire1), .arf_retire2(arf_retire2),
        .arf_write_addr1(arf_write_addr1), .arf_write_addr2(arf_write_addr2),
        .arf_write_data1(arf_write_data1), .arf_write_data2(arf_write_data2),
        .arf_old_addr1(arf_old_addr1), .arf_old_addr2(arf_old_addr2),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic int tag2();
`ifdef DUAL_RETIRE_EN
        return 2;
`else
        return 1;
`endif
    endfunction

    function automatic bit dual();
`ifdef DUAL_RETIRE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Retire monitor: every retire event pops the oldest expected entry
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            vectors++;
            if (arf_write_back !== (arf_retire1 | arf_retire2)) begin
                miscompares++;
                $display("FAIL write_back: got %b want %b", arf_write_back, arf_retire1 | arf_retire2);
            end
            if (arf_retire1 === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_retire1: got addr %0d data %h, want nothing", arf_write_addr1, arf_write_data1);
                end else begin
                    e = sb.pop_front();
                    if (e.port != 1 || arf_write_addr1 !== e.addr || arf_write_data1 !== e.data || arf_old_addr1 !== e.old) begin
                        miscompares++;
                        $display("FAIL retire1: got port1 addr %0d data %h old %0d, want port%0d addr %0d data %h old %0d",
                                 arf_write_addr1, arf_write_data1, arf_old_addr1, e.port, e.addr, e.data, e.old);
                    end
                end
            end
            if (arf_retire2 === 1'b1) begin
                vectors++;
                if (sb.size() == 0 || arf_retire1 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL unexpected_retire2: got addr %0d data %h, want nothing", arf_write_addr2, arf_write_data2);
                end else begin
                    e = sb.pop_front();
                    if (e.port != 2 || arf_write_addr2 !== e.addr || arf_write_data2 !== e.data || arf_old_addr2 !== e.old) begin
                        miscompares++;
                        $display("FAIL retire2: got port2 addr %0d data %h old %0d, want port%0d addr %0d data %h old %0d",
                                 arf_write_addr2, arf_write_data2, arf_old_addr2, e.port, e.addr, e.data, e.old);
                    end
                end
            end
            if (!dual()) begin
                vectors++;
                if ({arf_retire2, arf_write_addr2, arf_write_data2, arf_old_addr2} !== '0) begin
                    miscompares++;
                    $display("FAIL port2_tied: got r2 %b addr %0d data %h old %0d, want all 0",
                             arf_retire2, arf_write_addr2, arf_write_data2, arf_old_addr2);
                end
            end
        end
    end

    task automatic drive(input logic av, input logic [5:0] arch, input logic [5:0] phys,
                         input logic cv, input logic [3:0] cidx, input logic [31:0] cdata, input logic fl);
        alloc_valid = av; alloc_arch = arch; alloc_phys = phys;
        cmpl_valid = cv; cmpl_idx = cidx; cmpl_data = cdata; flush = fl;
        @(negedge clk);
        alloc_valid = 1'b0; cmpl_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic alloc(input logic [5:0] arch, input logic [5:0] phys);
        drive(1'b1, arch, phys, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic complete(input logic [3:0] idx, input logic [31:0] data);
        drive(1'b0, 6'd0, 6'd0, 1'b1, idx, data, 1'b0);
    endtask

    task automatic push(input int port, input logic [5:0] addr, input logic [31:0] data, input logic [5:0] old);
        exp_t e;
        e.port = port; e.addr = addr; e.data = data; e.old = old;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_count(input logic [4:0] target, input string name);
        int n = 0;
        while (count !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (count !== target) begin
            miscompares++;
            $display("FAIL %s_timeout: got count %0d want %0d", name, count, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({arf_write_back, arf_retire1, arf_retire2, arf_write_addr1, arf_write_data1, arf_old_addr1} !== '0) begin
            miscompares++;
            $display("FAIL reset_arf: got r1 %b addr1 %0d data1 %h, want 0", arf_retire1, arf_write_addr1, arf_write_data1);
        end
        do_reset();
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: got count %0d empty %b ready %b idx %0d, want 0 1 1 0", count, empty, alloc_ready, alloc_idx);
        end
    endtask

    task automatic test_dual_retire();
        do_reset();
        alloc(6'd3, 6'd40);
        vectors++;
        if (alloc_idx !== 4'd1) begin
            miscompares++;
            $display("FAIL alloc_idx: got %0d want 1", alloc_idx);
        end
        alloc(6'd5, 6'd41);
        complete(4'd1, 32'd22);
        push(1, 6'd40, 32'd11, 6'd3);
        push(tag2(), 6'd41, 32'd22, 6'd5);
        complete(4'd0, 32'd11);
        @(negedge clk);
        vectors++;
        if (arf_retire1 !== 1'b1 || arf_retire2 !== dual() || count !== (dual() ? 5'd0 : 5'd1)) begin
            miscompares++;
            $display("FAIL dual_latency: got r1 %b r2 %b count %0d, want 1 %b %0d",
                     arf_retire1, arf_retire2, count, dual(), dual() ? 0 : 1);
        end
        wait_count(5'd0, "dual_drain");
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) alloc(6'(i), 6'(16 + i));
        vectors++;
        if (count !== 5'd16 || alloc_ready !== 1'b0 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL full: got count %0d ready %b empty %b, want 16 0 0", count, alloc_ready, empty);
        end
        alloc(6'd9, 6'd9);
        vectors++;
        if (count !== 5'd16 || alloc_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL full_ignore: got count %0d idx %0d, want 16 0", count, alloc_idx);
        end
        push(1, 6'd16, 32'h100, 6'd0);
        complete(4'd0, 32'h100);
        alloc(6'd10, 6'd10);
        vectors++;
        if (count !== 5'd15 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL full_retire: got count %0d ready %b idx %0d, want 15 1 0", count, alloc_ready, alloc_idx);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) alloc(6'(i), 6'(i));
        for (int i = 0; i < 15; i++) push((i % 2 == 1) ? tag2() : 1, 6'(i), 32'h1000 + 32'(i), 6'(i));
        for (int i = 14; i >= 0; i--) complete(4'(i), 32'h1000 + 32'(i));
        wait_count(5'd0, "wrap_prefill");
        vectors++;
        if (alloc_idx !== 4'd15) begin
            miscompares++;
            $display("FAIL wrap_tail: got idx %0d want 15", alloc_idx);
        end
        alloc(6'd1, 6'd50);
        alloc(6'd2, 6'd51);
        push(1, 6'd50, 32'hF0, 6'd1);
        push(tag2(), 6'd51, 32'hA0, 6'd2);
        complete(4'd0, 32'hA0);
        complete(4'd15, 32'hF0);
        @(negedge clk);
        vectors++;
        if (arf_retire1 !== 1'b1 || arf_retire2 !== dual() || count !== (dual() ? 5'd0 : 5'd1)) begin
            miscompares++;
            $display("FAIL wrap_retire: got r1 %b r2 %b count %0d, want 1 %b %0d",
                     arf_retire1, arf_retire2, count, dual(), dual() ? 0 : 1);
        end
        wait_count(5'd0, "wrap_drain");
        vectors++;
        if (alloc_idx !== 4'd1) begin
            miscompares++;
            $display("FAIL wrap_tail1: got idx %0d want 1", alloc_idx);
        end
        alloc(6'd3, 6'd52);
        push(1, 6'd52, 32'h52, 6'd3);
        complete(4'd1, 32'h52);
        @(negedge clk);
        vectors++;
        if (arf_retire1 !== 1'b1 || arf_write_addr1 !== 6'd52 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL wrap_head1: got r1 %b addr %0d count %0d, want 1 52 0", arf_retire1, arf_write_addr1, count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) alloc(6'(20 + i), 6'(30 + i));
        complete(4'd1, 32'h11);
        complete(4'd2, 32'h22);
        drive(1'b1, 6'd7, 6'd7, 1'b1, 4'd0, 32'h77, 1'b1);
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || alloc_idx !== 4'd0 || arf_retire1 !== 1'b0 || arf_retire2 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_state: got count %0d empty %b idx %0d r1 %b r2 %b, want 0 1 0 0 0",
                     count, empty, alloc_idx, arf_retire1, arf_retire2);
        end
        complete(4'd1, 32'h55);
        complete(4'd2, 32'h66);
        repeat (3) @(negedge clk);
        vectors++;
        if (count !== 5'd0) begin
            miscompares++;
            $display("FAIL flush_stale_cmpl: got count %0d want 0", count);
        end
        alloc(6'd8, 6'd60);
        alloc(6'd9, 6'd61);
        push(1, 6'd60, 32'h99, 6'd8);
        complete(4'd0, 32'h99);
        @(negedge clk);
        vectors++;
        if (arf_retire1 !== 1'b1 || arf_retire2 !== 1'b0 || count !== 5'd1) begin
            miscompares++;
            $display("FAIL flush_realloc: got r1 %b r2 %b count %0d, want 1 0 1", arf_retire1, arf_retire2, count);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (count !== 5'd1) begin
            miscompares++;
            $display("FAIL flush_idx1_done: got count %0d want 1", count);
        end
    endtask

    task automatic test_unalloc_cmpl();
        do_reset();
        complete(4'd7, 32'hDEAD);
        repeat (2) @(negedge clk);
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || arf_retire1 !== 1'b0) begin
            miscompares++;
            $display("FAIL unalloc_cmpl: got count %0d empty %b r1 %b, want 0 1 0", count, empty, arf_retire1);
        end
        for (int i = 0; i < 8; i++) alloc(6'(i), 6'(40 + i));
        for (int i = 0; i < 7; i++) push((i % 2 == 1) ? tag2() : 1, 6'(40 + i), 32'h200 + 32'(i), 6'(i));
        for (int i = 6; i >= 0; i--) complete(4'(i), 32'h200 + 32'(i));
        wait_count(5'd1, "unalloc_drain");
        repeat (3) @(negedge clk);
        vectors++;
        if (count !== 5'd1) begin
            miscompares++;
            $display("FAIL slot7_not_done: got count %0d want 1", count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_dual_retire();
        test_full();
        test_wrap();
        test_flush();
        test_unalloc_cmpl();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
